// File: rtl/ram_sp_param_pkg.sv
// Shared constants for the parametrised single-port RAM:
// read-during-write mode encodings and clear-FSM state encodings.
package ram_pkg;

    // Behaviour of dout/dout_vld on a write access
    localparam int RD_READ_FIRST  = 0;
    localparam int RD_WRITE_FIRST = 1;
    localparam int RD_NO_CHANGE   = 2;

    // Clear-sweep FSM states
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

endpackage

// File: rtl/ram_sp_param_if.sv
// Access bus of the single-port RAM. The requester uses the master modport,
// the RAM uses the slave modport.
interface ram_sp_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) ();
    logic              clr;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              busy;

    modport master (output clr, en, we, addr, din,
                    input  dout, dout_vld, busy);
    modport slave  (input  clr, en, we, addr, din,
                    output dout, dout_vld, busy);
endinterface

// File: rtl/ram_sp_param_clr_fsm.sv
// Clear engine: after reset or an accepted clr pulse it walks every word
// once, emitting a write strobe/address that overrides the user port.
module ram_clr_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // Next state: sweep one word per cycle, leave after the last word
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // State registers; reset always restarts the sweep from word 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_we_o   = busy_o;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with read-valid strobe,
// selectable read-during-write mode and a sequential clear sweep.
// Optional feature: define RAM_OUT_REG_EN for an extra output register
// stage (read latency 2 instead of 1).
module ram_sp_param
    import ram_pkg::*;
#(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 6,
    parameter int                 DEPTH   = 64,
    parameter int                 RD_MODE = RD_NO_CHANGE,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_sp_param_if.slave bus
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy, clr_we;
    logic [ADDR_W-1:0] clr_addr;

    ram_clr_fsm #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (bus.clr),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr),
        .busy_o    (busy)
    );

    // clr beats a simultaneous access; nothing is accepted while sweeping
    logic clr_go, acc, in_rng;
    assign clr_go = rst_n & ~busy & bus.clr;
    assign acc    = rst_n & ~busy & ~bus.clr & bus.en;
    assign in_rng = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));

    // Words outside DEPTH read as zero
    logic [DATA_W-1:0] rd_word;
    assign rd_word = in_rng ? mem[bus.addr] : '0;

    // Write mux: the sweep owns the array while busy
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    always_comb begin
        wr_en   = acc & bus.we & in_rng;
        wr_addr = bus.addr;
        wr_data = bus.din;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = CLR_VAL;
        end
    end

    // Memory array, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-data selection; an out-of-range write reports 0 in the
    // modes that return data, since the word does not exist
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;
    always_comb begin
        dout_d = dout_q;
        vld_d  = 1'b0;
        if (acc) begin
            if (!bus.we) begin
                dout_d = rd_word;
                vld_d  = 1'b1;
            end else if (RD_MODE == RD_READ_FIRST) begin
                dout_d = rd_word;
                vld_d  = 1'b1;
            end else if (RD_MODE == RD_WRITE_FIRST) begin
                dout_d = in_rng ? bus.din : '0;
                vld_d  = 1'b1;
            end
        end
    end

    // First output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_W-1:0] dout2_q;
    logic              vld2_q;

    // Extra output stage; an accepted clr kills the strobe still in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout2_q <= '0;
            vld2_q  <= 1'b0;
        end else begin
            dout2_q <= dout_q;
            vld2_q  <= vld_q & ~clr_go;
        end
    end

    assign bus.dout     = dout2_q;
    assign bus.dout_vld = vld2_q;
`else
    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;
`endif

    assign bus.busy = busy;

endmodule
